bin2bcd_display: RTL
====================

# bin2bcd_display

Sequential binary-to-BCD converter using shift-and-add-3 (double dabble). It sits directly upstream of the MAX7219 8-digit display driver. It turns a binary count into packed BCD, so the driver's nibble-to-segment decode shows decimal digits instead of hex. Results are held stable between conversions, so the display driver can sample `bcd_out` at any time. Overflow is shown as all-`F`.

## Interface
- `BIN_WIDTH`, default 27: width of the binary input. The minimum is 4. 27 bits covers 0..134,217,727.
- `DIGITS`, default 8: number of BCD digits produced. `4*DIGITS` equals the display driver's 32-bit value.
- `clk` input, 1 bit: system clock (50 MHz). All logic is on the rising edge.
- `rst` input, 1 bit: synchronous, active-high reset.
- `start` input, 1 bit: conversion request. It is sampled only while idle.
- `bin_in` input, `BIN_WIDTH` bits: binary value. It is latched on the cycle `start` is accepted.
- `busy` output, 1 bit: high while a conversion is in progress.
- `done` output, 1 bit: one-cycle pulse when `bcd_out` and `overflow` update.
- `bcd_out` output, `4*DIGITS` bits: packed BCD result. The most significant digit is in the top nibble. It feeds the display driver's `display_value`.
- `overflow` output, 1 bit: high when the last conversion's input exceeded 10^DIGITS − 1.

## Operation
- Clocking and reset:
  - One clock, `clk`.
  - Reset is synchronous and active-high on `rst`.
  - Reset values: `busy`=0, `done`=0, `overflow`=0, `bcd_out`=0, state=IDLE, iteration counter=0.
  - `rst` asserted mid-conversion aborts it. No `done` pulse follows, and `bcd_out` is forced to 0.
- States:
  - IDLE: `busy`=0. When `start`=1:
    - latch `bin_in` into the shift register;
    - clear the BCD working register (`4*DIGITS` bits) and the sticky overflow flag;
    - load the counter with `BIN_WIDTH`;
    - go to SHIFT.
  - SHIFT: `busy`=1. Each cycle performs one iteration:
    - every 4-bit digit of the working register that is ≥5 gets +3, all digits in parallel;
    - the concatenation {working, shift register} then shifts left by 1;
    - the bit shifted out of the top of the working register is ORed into the sticky overflow flag;
    - the counter decrements.
  - Last iteration (counter = 1 before decrement):
    - `bcd_out` ← all-ones (`F` in every digit) if overflow, including this cycle's shift-out; otherwise the shifted working register;
    - `overflow` ← the sticky flag, including this cycle's shift-out;
    - `done` ← 1 for one cycle;
    - state ← IDLE.
- Arithmetic:
  - The +3 adjust is 4 bits per digit and never carries between digits.
  - The shift register is `BIN_WIDTH` bits; its MSB feeds the working register's LSB.
- Output stability:
  - `bcd_out` and `overflow` change only on the `done` cycle or on reset.
  - They hold their previous result throughout SHIFT.
- Handshake rules:
  - `start` while `busy`=1 is ignored. It is not queued, and `bin_in` changes are not seen.
  - `start`=1 in the same cycle `done`=1 is accepted, because state is already IDLE. Back-to-back conversions therefore run every `BIN_WIDTH`+1 cycles.
  - `start` held high continuously gives continuous conversion, with `bin_in` resampled at each acceptance.
  - `rst`=1 and `start`=1 in the same cycle: reset wins and the start is dropped.

## Timing
- Start is accepted on edge k: `busy`=1 after edge k.
- Iterations run on edges k+1 .. k+`BIN_WIDTH`.
- After edge k+`BIN_WIDTH`:
  - `busy`=0, `done`=1, and the new `bcd_out`/`overflow` are visible;
  - `done` is 0 after edge k+`BIN_WIDTH`+1 unless another conversion ends.
- Latency is `BIN_WIDTH` cycles from accepted start to `done` (27 at default).
- All outputs are registered, with no combinational path from inputs to outputs.
- The counter width is ceil(log2(`BIN_WIDTH`+1)).
- The display driver refreshes far slower than conversion. No handshake back from the driver is required.

## Test plan
- Reset, then `bin_in`=0 with a start pulse:
  - `busy` is high for exactly 27 cycles;
  - `done` pulses once;
  - `bcd_out`=0x00000000, `overflow`=0.
- `bin_in`=12,345,678 → `bcd_out`=0x12345678, `overflow`=0. Then `bin_in`=99,999,999 → 0x99999999, `overflow`=0. Then `bin_in`=5 → 0x00000005.
- Overflow cases:
  - `bin_in`=100,000,000 → `bcd_out`=0xFFFFFFFF, `overflow`=1;
  - `bin_in`=134,217,727 → same result;
  - a following `bin_in`=42 → 0x00000042, `overflow`=0.
- Start during busy:
  - start with 1,000, then pulse start with 2,000 at cycle 10 of the conversion;
  - expect a single `done` with 0x00001000;
  - `bcd_out` keeps its prior value until that `done`.
- Start held high with `bin_in` stepping 7 → 8 → 9:
  - `done` every 28 cycles;
  - results are 0x7, 0x8, 0x9 in order;
  - no gap cycle beyond `BIN_WIDTH`+1.
- Reset at cycle 13 of a conversion of 87,654,321:
  - next cycle shows `busy`=0, `bcd_out`=0, no `done`;
  - a new start afterwards converts correctly.

Source files
------------

// File: rtl/bin2bcd_display.sv
// Sequential binary-to-BCD converter (shift-and-add-3), one bit per cycle, BIN_WIDTH cycles per result.
// Results stay held between conversions; a start request is only taken while idle.
module bin2bcd_display #(
  parameter int BIN_WIDTH = 27,
  parameter int DIGITS    = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [BIN_WIDTH-1:0]  bin_in,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic                  overflow
);

  localparam int BW = 4 * DIGITS;
  localparam int CW = $clog2(BIN_WIDTH + 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t               state;
  logic [BIN_WIDTH-1:0] shift_reg;
  logic [BW-1:0]        work;
  logic                 ovf_sticky;
  logic [CW-1:0]        cnt;

  logic [BW-1:0]        adjusted;
  logic [BW-1:0]        work_next;
  logic                 shift_out;
  logic                 ovf_next;

  // Add-3 is done per nibble so no carry crosses a digit boundary.
  always_comb begin
    adjusted = work;
    for (int d = 0; d < DIGITS; d++) begin
      if (work[4*d +: 4] >= 4'd5)
        adjusted[4*d +: 4] = work[4*d +: 4] + 4'd3;
    end
  end

  assign work_next = {adjusted[BW-2:0], shift_reg[BIN_WIDTH-1]};
  assign shift_out = adjusted[BW-1];
  assign ovf_next  = ovf_sticky | shift_out;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      shift_reg  <= '0;
      work       <= '0;
      ovf_sticky <= 1'b0;
      cnt        <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      bcd_out    <= '0;
      overflow   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            shift_reg  <= bin_in;
            work       <= '0;
            ovf_sticky <= 1'b0;
            cnt        <= CW'(BIN_WIDTH);
            busy       <= 1'b1;
            state      <= SHIFT;
          end
        end
        SHIFT: begin
          shift_reg  <= {shift_reg[BIN_WIDTH-2:0], 1'b0};
          work       <= work_next;
          ovf_sticky <= ovf_next;
          cnt        <= cnt - 1'b1;
          if (cnt == CW'(1)) begin
            bcd_out  <= ovf_next ? {BW{1'b1}} : work_next;
            overflow <= ovf_next;
            done     <= 1'b1;
            busy     <= 1'b0;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
